// File: rtl/bram_tile_access_gen_if.sv
// Control and BRAM-port bundle for bram_tile_access_gen.
// master drives the control inputs, slave is the generator.
interface bram_tile_access_gen_if #(
  parameter int ADDR_WIDTH = 11,
  parameter int BEAT_W     = 5
);
  logic                  start;
  logic                  mode;
  logic [BEAT_W-1:0]     beats;
  logic                  reset_tile_ptr;
  logic                  stall;
  logic [ADDR_WIDTH-1:0] bram_addr;
  logic                  bram_en;
  logic                  bram_we;
  logic                  rd_valid;
  logic                  rd_last;
  logic                  busy;
  logic                  done;
  logic                  err_start;
  logic                  ovf;

  modport master (
    output start, mode, beats, reset_tile_ptr, stall,
    input  bram_addr, bram_en, bram_we, rd_valid, rd_last,
    input  busy, done, err_start, ovf
  );

  modport slave (
    input  start, mode, beats, reset_tile_ptr, stall,
    output bram_addr, bram_en, bram_we, rd_valid, rd_last,
    output busy, done, err_start, ovf
  );
endinterface

// File: rtl/bram_tile_access_gen.sv
// Tile read/write address generator for one BRAM port.
// TILE_PTR_WRAP_EN: wrap tile pointer at limit, ovf pulses.
module bram_tile_access_gen #(
  parameter int ADDR_WIDTH   = 11,
  parameter int MAX_BEATS    = 16,
  parameter int BEAT_W       = $clog2(MAX_BEATS+1),
  parameter int TILE_W       = 9,
  parameter int NUM_TILES    = 64,
  parameter int READ_LATENCY = 1
) (
  input logic                   clk,
  input logic                   rst_n,
  bram_tile_access_gen_if.slave bus
);
  localparam int SH = $clog2(MAX_BEATS);
  localparam int WW = ADDR_WIDTH + TILE_W;
  localparam int RL = READ_LATENCY;
  localparam logic [TILE_W-1:0] PTR_MAX = TILE_W'(NUM_TILES-1);
  localparam logic [BEAT_W-1:0] BMAX = BEAT_W'(MAX_BEATS);

  typedef enum logic [1:0] {IDLE, ACCESS, DRAIN, DONE} state_t;

  state_t              state_q, state_d;
  logic                mode_q, mode_d;
  logic [BEAT_W-1:0]   beats_q, beats_d;
  logic [BEAT_W-1:0]   off_q, off_d;
  logic [TILE_W-1:0]   base_q, base_d;
  logic [TILE_W-1:0]   ptr_q, ptr_d;
  logic                ovf_q, ovf_d;
  logic                err_q, err_d;
  logic [RL-1:0]       rdv_q, rdv_d;
  logic [RL-1:0]       rdl_q, rdl_d;
  logic                issue, last_beat, beats_ok;
  logic                rd_v, rd_l;
  logic [WW-1:0]       addr_w;

  assign beats_ok  = (bus.beats != '0) && (bus.beats <= BMAX);
  assign last_beat = (off_q == beats_q - BEAT_W'(1));
  assign issue     = (state_q == ACCESS) && !bus.stall;
  assign rd_v      = rdv_q[RL-1];
  assign rd_l      = rdl_q[RL-1];

  // Idle shows the next tile base; otherwise the in-flight beat address.
  always_comb begin
    if (state_q == IDLE)
      addr_w = WW'(ptr_q) << SH;
    else
      addr_w = (WW'(base_q) << SH) + WW'(off_q);
  end

  // Next state, tile pointer, error pulse and read-tag pipeline.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    beats_d = beats_q;
    off_d   = off_q;
    base_d  = base_q;
    ptr_d   = ptr_q;
`ifdef TILE_PTR_WRAP_EN
    ovf_d   = 1'b0;
`else
    ovf_d   = ovf_q;
`endif
    err_d   = 1'b0;
    rdv_d   = (rdv_q << 1) | RL'(issue & ~mode_q);
    rdl_d   = (rdl_q << 1) | RL'(issue & ~mode_q & last_beat);
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (beats_ok) begin
            mode_d  = bus.mode;
            beats_d = bus.beats;
            base_d  = ptr_q;
            off_d   = '0;
            state_d = ACCESS;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ACCESS: begin
        err_d = bus.start;
        if (issue) begin
          off_d = off_q + BEAT_W'(1);
          if (last_beat)
            state_d = mode_q ? DONE : DRAIN;
        end
      end
      DRAIN: begin
        err_d = bus.start;
        if (rd_v && rd_l)
          state_d = DONE;
      end
      DONE: begin
        err_d   = bus.start;
        state_d = IDLE;
        if (ptr_q == PTR_MAX) begin
`ifdef TILE_PTR_WRAP_EN
          ptr_d = '0;
`endif
          ovf_d = 1'b1;
        end else begin
          ptr_d = ptr_q + TILE_W'(1);
        end
      end
    endcase
    if (bus.reset_tile_ptr) begin
      ptr_d = '0;
      ovf_d = 1'b0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
      beats_q <= '0;
      off_q   <= '0;
      base_q  <= '0;
      ptr_q   <= '0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
      rdv_q   <= '0;
      rdl_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      beats_q <= beats_d;
      off_q   <= off_d;
      base_q  <= base_d;
      ptr_q   <= ptr_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
      rdv_q   <= rdv_d;
      rdl_q   <= rdl_d;
    end
  end

  assign bus.bram_addr = ADDR_WIDTH'(addr_w);
  assign bus.bram_en   = issue;
  assign bus.bram_we   = issue & mode_q;
  assign bus.rd_valid  = rd_v;
  assign bus.rd_last   = rd_l;
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DONE);
  assign bus.err_start = err_q;
  assign bus.ovf       = ovf_q;
endmodule
